mux_scan_serializer: RTL and testbench
======================================

// Module: mux_scan_serializer
// PURPOSE
//  Upstream sequencer for the 24:1 result mux. Steps the mux select through
//  entries 0..len-1 and registers each selected 12-bit value. Emits the values
//  as a valid/ready stream to the output/readback path, one beat per entry.
//  Parks the select at 31 when idle, so the mux output is zero.
// PARAMETERS
//  DATA_WIDTH   12   width of the mux data and of out_data
//  NUM_INPUTS   24   number of mux inputs; the maximum scan length
// PORTS
//  clk        in   1            single clock; rising edge
//  reset      in   1            synchronous, active-high
//  start      in   1            one-cycle scan request; sampled only in IDLE
//  len        in   5            number of entries to scan; captured with start
//  sel        out  5            mux select; drives the mux sel input
//  mux_data   in   DATA_WIDTH   mux output (combinational from sel)
//  out_data   out  DATA_WIDTH   registered stream data
//  out_idx    out  5            entry index of out_data
//  out_valid  out  1            stream valid
//  out_ready  in   1            stream ready
//  out_last   out  1            marks the final beat of the scan
//  busy       out  1            high from the cycle after start until the scan completes
//  done       out  1            one-cycle pulse when the scan completes
// BEHAVIOUR
//  Reset (sync, active-high; overrides all other activity, including mid-scan):
//   - state=IDLE, sel=5'd31, out_data=0, out_idx=0.
//   - out_valid=0, out_last=0, busy=0, done=0.
//  Length rule:
//   - len_q = (len > NUM_INPUTS) ? NUM_INPUTS : len, latched at start.
//   - len is ignored at all other times.
//  FSM states: IDLE, SCAN, DRAIN.
//  IDLE:
//   - sel=31. If start: len_q==0 -> done=1 next cycle, stay IDLE, no beats.
//   - Otherwise -> SCAN with idx=0 and sel=0 in the next cycle.
//  SCAN:
//   - sel=idx (registered). Capture happens when the output register is free,
//     i.e. !out_valid || out_ready.
//   - On capture: out_data<=mux_data, out_idx<=idx, out_valid<=1,
//     out_last<=(idx==len_q-1).
//   - If that was the last index -> DRAIN, sel<=31. Else idx<=idx+1, sel<=idx+1.
//   - If out_valid && !out_ready: hold idx, sel, out_data, out_idx, out_last
//     stable. No drop, no duplicate.
//  DRAIN:
//   - Hold the last beat until out_valid && out_ready.
//   - On that edge: out_valid<=0, out_last<=0, busy<=0, done<=1 (one cycle),
//     state->IDLE.
//   - A start coincident with the done cycle is accepted; the FSM is in IDLE.
//  Handshake:
//   - A beat transfers on a rising edge with out_valid && out_ready.
//   - out_valid never drops without a transfer, except on reset.
//  Latency and throughput:
//   - start in cycle T -> sel=0 in T+1 -> first out_valid in T+2.
//   - With out_ready held high, 1 beat/cycle. The last beat is in T+1+len_q;
//     done is in T+2+len_q.
//  Other rules:
//   - start while busy is ignored; len_q is not changed.
//   - mux_data is sampled only on capture edges. sel never exceeds len_q-1
//     during SCAN.
// TESTING
//  1 len=24, out_ready=1, mux inputs in_k=k+100: 24 consecutive beats,
//    data 100..123, idx 0..23, last only on idx 23, done 1 cycle later.
//  2 len=5, out_ready toggling 1,0,0,1,...: exactly 5 transfers, data
//    in0..in4 in order; sel and out_data stable while stalled.
//  3 len=0 start: no out_valid ever, done pulses in cycle T+1, busy stays 0.
//  4 len=30 start: clamped; 24 beats, last on idx 23.
//  5 reset asserted during beat 7 of a len=24 scan: the next cycle shows
//    sel=31, out_valid=0, busy=0, done=0. A new start then scans from idx 0.
//  6 start pulsed during SCAN: ignored, beat count unchanged. start on the
//    done cycle: a new scan starts, first out_valid 2 cycles later.

Source files
------------

// File: rtl/mux_scan_serializer.sv
// Sequencer for the 24:1 result mux: steps sel through 0..len-1, registers each
// selected word and emits it as a valid/ready stream, one beat per entry.
module mux_scan_serializer #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_INPUTS = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4:0]            len,
  output logic [4:0]            sel,
  input  logic [DATA_WIDTH-1:0] mux_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [4:0]            out_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Select 31 is an unconnected mux input, so the parked mux output is zero.
  localparam logic [4:0] SEL_PARK = 5'd31;
  localparam logic [4:0] MAX_LEN  = 5'(NUM_INPUTS);

  state_e                state_q, state_d;
  logic [4:0]            sel_q, sel_d;
  logic [4:0]            len_q, len_d;
  logic [4:0]            out_idx_q, out_idx_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [4:0] len_clamped;
  logic       out_free;
  logic       capture;
  logic       last_idx;
  logic       xfer;

  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  assign out_free    = !out_valid_q || out_ready;
  assign capture     = (state_q == SCAN) && out_free;
  assign last_idx    = (sel_q == len_q - 5'd1);
  assign xfer        = out_valid_q && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= SEL_PARK;
      len_q       <= '0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      len_q       <= len_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // NOTE: every signal assigned in a combinational block gets a default first,
  // otherwise paths that skip the assignment infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && len_clamped != 5'd0) state_d = SCAN;
      SCAN:    if (capture && last_idx)          state_d = DRAIN;
      DRAIN:   if (xfer)                         state_d = IDLE;
      default:                                   state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d       = sel_q;
    len_d       = len_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d = len_clamped;
          if (len_clamped == 5'd0) begin
            done_d = 1'b1;
          end else begin
            sel_d  = 5'd0;
            busy_d = 1'b1;
          end
        end
      end
      SCAN: begin
        // A stalled beat blocks capture, so sel and the output register hold.
        if (capture) begin
          out_data_d  = mux_data;
          out_idx_d   = sel_q;
          out_valid_d = 1'b1;
          out_last_d  = last_idx;
          sel_d       = last_idx ? SEL_PARK : sel_q + 5'd1;
        end
      end
      DRAIN: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: begin
        sel_d       = SEL_PARK;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Self-checking bench for mux_scan_serializer: table-driven scans, random scans
// against an entry-list reference model, and hand-written reset/restart sequences.
module tb_mux_scan_serializer;

  localparam int DW = 12;
  localparam int NI = 24;

  typedef struct {
    logic [4:0] len;
    int         mode;       // 0: ready high, 1: ready 1,0,0 repeating, 2: random ready
    bit         ramp;       // in_k = k+100 instead of random data
    int         exp_beats;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [4:0]    len;
  logic [4:0]    sel;
  logic [DW-1:0] mux_data;
  logic [DW-1:0] out_data;
  logic [4:0]    out_idx;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mux_in [NI];

  int n_pass  = 0;
  int n_total = 0;

  mux_scan_serializer #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .sel       (sel),
    .mux_data  (mux_data),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Behavioural 24:1 mux; unconnected selects read as zero.
  always_comb begin
    mux_data = '0;
    if (int'(sel) < NI) mux_data = mux_in[sel];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic load_mux(input bit ramp);
    for (int k = 0; k < NI; k++) mux_in[k] = ramp ? DW'(k + 100) : DW'($urandom);
  endtask

  // Starts a scan at the current negedge and follows it to its done cycle,
  // returning at the negedge of that cycle (a caller may start again there).
  task automatic run_scan(input logic [4:0] l, input int mode, input int exp_beats,
                          input bit start_mid);
    int            eff;
    int            exp_idx[$];
    logic [DW-1:0] snap [NI];
    int            cyc, beats, first_valid, done_cyc, last_xfer, k;
    bit            r, prev_stall, saw_busy;
    logic [DW-1:0] prev_data;
    logic [4:0]    prev_idx, prev_sel;
    logic          prev_last;

    eff = (int'(l) > NI) ? NI : int'(l);
    for (int i = 0; i < eff; i++) exp_idx.push_back(i);
    for (int i = 0; i < NI; i++) snap[i] = mux_in[i];

    start     = 1'b1;
    len       = l;
    out_ready = (mode == 0);
    @(negedge clk);
    start = 1'b0;
    len   = 5'($urandom);

    cyc = 1; beats = 0; first_valid = -1; done_cyc = -1; last_xfer = -1;
    prev_stall = 1'b0; saw_busy = 1'b0;
    prev_data = '0; prev_idx = '0; prev_sel = '0; prev_last = 1'b0;

    while (done_cyc < 0 && cyc <= 200) begin
      if (cyc == 1) check("sel_after_start", 32'(sel), (eff > 0) ? 32'd0 : 32'd31);
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
        check("stall_idx", 32'(out_idx), 32'(prev_idx));
        check("stall_last", 32'(out_last), 32'(prev_last));
        check("stall_sel", 32'(sel), 32'(prev_sel));
      end
      if (busy) saw_busy = 1'b1;
      if (done) begin
        done_cyc = cyc;
        check("done_busy_low", 32'(busy), 32'd0);
        check("done_valid_low", 32'(out_valid), 32'd0);
        check("done_sel_park", 32'(sel), 32'd31);
      end else begin
        check("busy_level", 32'(busy), 32'(eff > 0));
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (eff > 0) check("sel_in_range", 32'((int'(sel) < eff) || sel == 5'd31), 32'd1);
        case (mode)
          0:       r = 1'b1;
          1:       r = ((cyc - 1) % 3 == 0);
          default: r = 1'($urandom);
        endcase
        start     = start_mid && (cyc == 3);
        len       = start ? 5'd2 : 5'($urandom);
        out_ready = r;
        if (out_valid && r) begin
          check("beat_in_range", 32'(beats < eff), 32'd1);
          if (exp_idx.size() > 0) begin
            k = exp_idx.pop_front();
            check("beat_data", 32'(out_data), 32'(snap[k]));
            check("beat_idx", 32'(out_idx), k);
            check("beat_last", 32'(out_last), 32'(k == eff - 1));
          end
          beats++;
          last_xfer = cyc;
        end
        prev_stall = out_valid && !r;
        prev_data  = out_data;
        prev_idx   = out_idx;
        prev_last  = out_last;
        prev_sel   = sel;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;

    check("done_seen", 32'(done_cyc > 0), 32'd1);
    check("beat_count", beats, exp_beats);
    check("entries_left", exp_idx.size(), 0);
    if (eff == 0) begin
      check("len0_done_cycle", done_cyc, 1);
      check("len0_no_valid", first_valid, -1);
      check("len0_busy_low", 32'(saw_busy), 32'd0);
    end else begin
      check("first_valid_cycle", first_valid, 2);
      check("done_after_last", done_cyc, last_xfer + 1);
      if (mode == 0) check("done_cycle", done_cyc, eff + 2);
    end
  endtask

  vec_t vecs [9];
  bit   found;
  logic [4:0] rl;

  initial begin
    vecs[0] = '{len: 5'd24, mode: 0, ramp: 1'b1, exp_beats: 24};
    vecs[1] = '{len: 5'd5,  mode: 1, ramp: 1'b0, exp_beats: 5};
    vecs[2] = '{len: 5'd0,  mode: 0, ramp: 1'b0, exp_beats: 0};
    vecs[3] = '{len: 5'd30, mode: 0, ramp: 1'b1, exp_beats: 24};
    vecs[4] = '{len: 5'd1,  mode: 0, ramp: 1'b0, exp_beats: 1};
    vecs[5] = '{len: 5'd7,  mode: 2, ramp: 1'b0, exp_beats: 7};
    vecs[6] = '{len: 5'd24, mode: 2, ramp: 1'b0, exp_beats: 24};
    vecs[7] = '{len: 5'd31, mode: 1, ramp: 1'b1, exp_beats: 24};
    vecs[8] = '{len: 5'd23, mode: 0, ramp: 1'b0, exp_beats: 23};

    reset = 1'b1; start = 1'b0; len = '0; out_ready = 1'b0;
    load_mux(1'b1);
    repeat (2) @(negedge clk);
    check("rst_sel", 32'(sel), 32'd31);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      load_mux(vecs[v].ramp);
      run_scan(vecs[v].len, vecs[v].mode, vecs[v].exp_beats, 1'b0);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_valid_low", 32'(out_valid), 32'd0);
      check("idle_sel_park", 32'(sel), 32'd31);
    end

    for (int n = 0; n < 6; n++) begin
      rl = 5'($urandom);
      load_mux(1'b0);
      run_scan(rl, 2, (int'(rl) > NI) ? NI : int'(rl), 1'b0);
      @(negedge clk);
    end

    // Reset while beat 7 of a full scan is on the output.
    load_mux(1'b1);
    start = 1'b1; len = 5'd24; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (out_valid && out_idx == 5'd7) found = 1'b1;
      else @(negedge clk);
    end
    check("reached_beat7", 32'(found), 32'd1);
    check("beat7_data", 32'(out_data), 32'd107);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_sel", 32'(sel), 32'd31);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    reset = 1'b0;
    run_scan(5'd24, 0, 24, 1'b0);
    @(negedge clk);

    // start pulsed mid-scan must be ignored and leave the length alone.
    load_mux(1'b0);
    run_scan(5'd10, 0, 10, 1'b1);
    @(negedge clk);
    load_mux(1'b0);
    run_scan(5'd9, 1, 9, 1'b1);

    // start on the done cycle launches the next scan immediately.
    load_mux(1'b0);
    run_scan(5'd4, 0, 4, 1'b0);
    load_mux(1'b0);
    run_scan(5'd6, 2, 6, 1'b0);
    run_scan(5'd0, 0, 0, 1'b0);
    run_scan(5'd3, 0, 3, 1'b0);
    @(negedge clk);
    check("final_idle_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
